// File: rtl/sensor_input_conditioner.sv
// sensor_input_conditioner: sync, debounce and startup-settle six raw sensor lines
module sensor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNT_WIDTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] raw_sensors,
  output logic [5:0] clean_sensors,
  output logic [5:0] sensors_changed,
  output logic       any_change,
  output logic       sensors_valid
);
  typedef enum logic [1:0] {INIT, SETTLE, RUN} state_t;
  localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  state_t state;
  logic [5:0] sync1, sync2, done;
  logic [COUNT_WIDTH-1:0] cnt [6];
  logic [COUNT_WIDTH-1:0] settle_cnt;
  logic [1:0] init_cnt;
  always_comb begin
    done = '0;
    for (int i = 0; i < 6; i++) done[i] = (sync2[i] != clean_sensors[i]) && (cnt[i] == LAST);
  end
  assign any_change = |sensors_changed;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= INIT;
      sync1 <= '0;
      sync2 <= '0;
      clean_sensors <= '0;
      sensors_changed <= '0;
      sensors_valid <= 1'b0;
      settle_cnt <= '0;
      init_cnt <= '0;
      for (int i = 0; i < 6; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw_sensors;
      sync2 <= sync1;
      sensors_changed <= (state == RUN) ? done : '0;
      if (state == INIT) begin
        // first clean value is taken straight from the filled synchroniser
        if (init_cnt == 2'd2) begin
          clean_sensors <= sync2;
          settle_cnt <= '0;
          state <= SETTLE;
        end else init_cnt <= init_cnt + 1'b1;
      end else begin
        for (int i = 0; i < 6; i++)
          cnt[i] <= (sync2[i] == clean_sensors[i] || done[i]) ? '0 : cnt[i] + 1'b1;
        clean_sensors <= clean_sensors ^ done;
        if (state == SETTLE) begin
          if (settle_cnt == LAST) begin
            state <= RUN;
            sensors_valid <= 1'b1;
          end else settle_cnt <= settle_cnt + 1'b1;
        end
      end
    end
  end
endmodule
